// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   arb_state_e : in-flight access tracked one cycle after a grant
//   gnt_sel_e   : requester encoding used by the round-robin last-grant pointer
//   REQ_I/REQ_D : bit positions of fetch/data in the req/gnt vectors
package mem_arbiter_pkg;

  localparam int unsigned REQ_N = 2;
  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2,
    WR_D = 2'd3
  } arb_state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } gnt_sel_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer.
//   clk, rst : clock and asynchronous active-high reset
//   req[1:0] : request vector (bit 0 fetch, bit 1 data)
//   accept   : a grant was taken this cycle; advances the pointer
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and pointer
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  gnt_sel_e last_q;
  gnt_sel_e last_d;

  // A lone requester wins outright; on conflict the one not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == SEL_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept && (gnt != 2'b00)) begin
      last_d = gnt[REQ_D] ? SEL_D : SEL_I;
    end
  end

  // Reset to fetch so data wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SEL_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port synchronous RAM (read data returns one cycle after re).
//   clk, rst                    : clock, asynchronous active-high reset
//   i_valid/i_addr/i_ready      : fetch request handshake
//   i_rvalid/i_rdata            : fetch response, one cycle after acceptance
//   d_valid/d_we/d_addr/d_wdata : load/store request
//   d_ready, d_rvalid, d_rdata  : data handshake and response (store ack has rdata 0)
//   mem_addr/mem_din/mem_re/mem_we/mem_dout : RAM port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] gnt;
  logic             accept;
  arb_state_e       state_q;

  // Requests are masked during reset so nothing is granted or issued.
  assign req    = {d_valid & ~rst, i_valid & ~rst};
  assign accept = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign i_ready = gnt[REQ_I];
  assign d_ready = gnt[REQ_D];

  // Remember which access is in flight; it completes in the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (gnt[REQ_I]) begin
      state_q <= RD_I;
    end else if (gnt[REQ_D]) begin
      state_q <= d_we ? WR_D : RD_D;
    end else begin
      state_q <= IDLE;
    end
  end

  // Issue the granted request to the RAM in the acceptance cycle.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (gnt[REQ_I]) begin
      mem_addr = i_addr;
      mem_re   = 1'b1;
    end else if (gnt[REQ_D]) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_we  = 1'b1;
        mem_din = d_wdata;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  // Route the RAM output to whichever requester owns the in-flight access.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    case (state_q)
      RD_I: begin
        i_rvalid = 1'b1;
        i_rdata  = mem_dout;
      end
      RD_D: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_dout;
      end
      WR_D:    d_rvalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width (matches ram addr = pc[31:2]).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid  in  1  fetch request pending.
REQ-006 SHALL have port i_addr  in  ADDR_W  fetch word address.
REQ-007 SHALL have port i_ready  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port i_rvalid  out  1  fetch read data valid.
REQ-009 SHALL have port i_rdata  out  DATA_W  fetch read data.
REQ-010 SHALL have port d_valid  in  1  load/store request pending.
REQ-011 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  in  ADDR_W  data word address.
REQ-013 SHALL have port d_wdata  in  DATA_W  store data (full word).
REQ-014 SHALL have port d_ready  out  1  data request accepted this cycle.
REQ-015 SHALL have port d_rvalid  out  1  load data valid / store acknowledge.
REQ-016 SHALL have port d_rdata  out  DATA_W  load data.
REQ-017 SHALL have ports mem_addr out ADDR_W, mem_din out DATA_W, mem_re out 1, mem_we out 1, mem_dout in DATA_W  to the single-port synchronous ram (dout valid one cycle after re).

Function
REQ-018 SHALL accept at most one request per cycle; acceptance = valid && ready in the same cycle; ready is combinational from valid and arbitration state.
REQ-019 SHALL drive the accepted request onto mem_* combinationally in the acceptance cycle: fetch -> mem_re=1; load -> mem_re=1; store -> mem_we=1, mem_din=d_wdata; never mem_re and mem_we together.
REQ-020 SHALL drive mem_addr=0, mem_din=0, mem_re=0, mem_we=0 when no request is accepted.
REQ-021 SHALL track the in-flight access in a state register with states IDLE, RD_I, RD_D, WR_D, loaded every cycle from that cycle's grant (IDLE if none).
REQ-022 SHALL respond exactly one cycle after acceptance: RD_I -> i_rvalid=1, i_rdata=mem_dout; RD_D -> d_rvalid=1, d_rdata=mem_dout; WR_D -> d_rvalid=1, d_rdata=0.
REQ-023 SHALL hold i_rdata/d_rdata at 0 and rvalid low when the state does not target that requester.
REQ-024 SHALL support back-to-back accesses: a new grant in the same cycle a response is returned, giving one access per cycle sustained.
REQ-025 SHALL arbitrate round-robin when both valid: grant the requester not granted most recently; a single valid requester is granted immediately regardless of pointer.
REQ-026 SHALL update the last-grant pointer only on acceptance.
REQ-027 SHALL guarantee a continuously valid requester waits at most one cycle.
REQ-028 SHALL require requesters to hold valid, addr, we, wdata stable until ready; behaviour on retraction before ready is unspecified but SHALL not produce a response.

Reset
REQ-029 SHALL on rst: state=IDLE, last-grant pointer=fetch (data wins the first conflict), all rvalid=0, all rdata=0, ready=0, mem_re=mem_we=0.
REQ-030 SHALL discard any in-flight access when rst asserts mid-operation; no response after reset release.
REQ-031 SHALL grant nothing while rst is high.

Structure
REQ-032 SHALL place the state enum (IDLE, RD_I, RD_D, WR_D) and the grant-select encoding in the shared cpu package.
REQ-033 SHALL implement the two-way round-robin pointer and grant logic as sub-module rr_arb2 (inputs req[1:0], accept; outputs gnt[1:0]).

Verification
REQ-034 SHALL cover: after reset, i_valid=1 i_addr=0x4, ram[4]=0x00000013 -> i_ready same cycle, mem_re=1 mem_addr=0x4, next cycle i_rvalid=1 i_rdata=0x00000013.
REQ-035 SHALL cover: i_valid and d_valid (load 0x10) both high from reset -> cycle0 grants data, cycle1 grants fetch, cycle2 grants data; no requester idles two consecutive cycles.
REQ-036 SHALL cover: store d_addr=0x20 d_wdata=0xDEADBEEF then load 0x20 back-to-back -> mem_we then mem_re on consecutive cycles, d_rvalid both following cycles, load returns 0xDEADBEEF, store ack d_rdata=0.
REQ-037 SHALL cover: fetch stream of 8 consecutive addresses with d_valid low -> i_ready every cycle, 8 i_rvalid pulses in order, 1-cycle latency each.
REQ-038 SHALL cover: rst asserted the cycle after a load is accepted -> d_rvalid stays 0, state IDLE, mem_re/mem_we 0 immediately (asynchronous).
REQ-039 SHALL cover: no valid inputs for 5 cycles -> mem_re=mem_we=0, mem_addr=0, both rvalid 0 throughout.
